m20k_port_ctrl: RTL and testbench
=================================

Name: m20k_port_ctrl

Overview:
- Request/response front-end for one port of an M20K-based 8192x2 dual-port memory macro. Instantiated once per memory port, directly upstream of the macro.
- Upstream side: a valid/ready request stream from an accelerator. Downstream side: the macro port pins (address, data, CE, WE, WEM, Q).
- The block converts the macro's fixed 1-cycle unregistered read latency into a backpressured response stream with bounded buffering.

Parameters:
- ADDR_W, 13, address width; must match the macro depth (8192 words).
- DATA_W, 2, data width; must match the macro width.
- RSP_DEPTH, 3, response FIFO entries. Allowed range is 1..8. The value 3 sustains one read per cycle while rsp_ready is held high.

Ports:
- CLK  in  1  single clock, shared with the macro.
- RST  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready are both high.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_wem  in  DATA_W  per-bit write mask.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer takes the read data.
- rsp_data  out  DATA_W  read data, returned in request order.
- mem_a  out  ADDR_W  to macro A.
- mem_d  out  DATA_W  to macro D.
- mem_ce  out  1  to macro CE.
- mem_we  out  1  to macro WE.
- mem_wem  out  DATA_W  to macro WEM.
- mem_q  in  DATA_W  from macro Q; valid the cycle after a read CE.

Behaviour:
- Reset:
  - CLK is the only clock. RST is asynchronous and active-high.
  - While RST is high: req_ready=0, rsp_valid=0, rsp_data=0, mem_ce=0, mem_we=0. The FIFO, the inflight flag and all counters are cleared.
- Memory drive:
  - All mem_* outputs are combinational from the request: mem_ce = req_valid & req_ready; mem_we = req_we.
  - mem_a, mem_d and mem_wem pass through req_addr, req_wdata and req_wem.
  - The macro samples these at the next CLK edge.
- Writes:
  - Always accepted when not in reset: req_ready = ~RST & (req_we | credit).
  - A write produces no response.
- Read credits:
  - occ = fifo_count + inflight, where inflight is 1 if a read was accepted in the previous cycle.
  - credit = (occ < RSP_DEPTH). credit does not depend on rsp_ready (no comb path from rsp_ready to req_ready).
- Read pipeline:
  - On acceptance at edge N, inflight is set.
  - In cycle N+1, mem_q is pushed into the FIFO at the closing edge.
  - rsp_valid rises in cycle N+2. Minimum latency is 2 cycles from acceptance.
- FIFO:
  - Registered circular buffer with a wrap-around pointer modulo RSP_DEPTH.
  - Push and pop in the same cycle leave the count unchanged. Overflow is impossible by construction of the credit rule.
- Response stream:
  - rsp_valid = fifo_count != 0; rsp_data = head entry.
  - rsp_data holds stable while rsp_valid & ~rsp_ready.
- Ordering: responses are strictly in request order. Write→read to the same address returns the new data (the macro is NEW_DATA); no forwarding logic is needed.
- Reset mid-operation: inflight reads and buffered responses are discarded. No rsp_valid is generated for them after RST deasserts.

Optional Feature:
- Macro M20K_PORT_STATS_EN.
- When defined, adds three 16-bit outputs, each saturating at 0xFFFF and cleared by RST:
  - stat_rd: reads accepted.
  - stat_wr: writes accepted.
  - stat_stall: cycles with req_valid & ~req_ready.
- When undefined: the ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package m20k_pkg holds:
  - ADDR_W and DATA_W defaults.
  - The typedef for a request struct (we, addr, wdata, wem).
  - The typedef for the stats struct.
- Sub-module m20k_rsp_fifo: parameterised DATA_W x RSP_DEPTH FIFO with push, pop and count outputs.

Test Plan:
- Write addr 0x0005 data 2'b10 wem 2'b11, then read 0x0005 → rsp_data=2'b10, with rsp_valid exactly 2 cycles after read acceptance.
- Masked write: addr 0x1FFF holds 2'b11; write 2'b00 with wem 2'b01, then read → 2'b10.
- 8 back-to-back reads with rsp_ready=1 and RSP_DEPTH=3 → req_ready never drops; 8 in-order responses at 1 per cycle.
- rsp_ready=0 while issuing reads → exactly 3 accepted, then req_ready=0 for reads while writes are still accepted; release rsp_ready → data drains in order.
- Assert RST with 2 buffered responses plus 1 inflight → all outputs zero immediately; after release, no spurious rsp_valid.
- With M20K_PORT_STATS_EN: 5 reads, 3 writes, 4 stall cycles → stat_rd=5, stat_wr=3, stat_stall=4; forcing 70000 stalls → stat_stall=0xFFFF.

Source files
------------

// File: rtl/m20k_pkg.sv
// Shared types and defaults for the M20K port controller.
// M20K_PORT_STATS_EN enables the statistics counters.
package m20k_pkg;

    localparam int M20K_ADDR_W = 13;
    localparam int M20K_DATA_W = 2;
    localparam int STAT_W      = 16;

    typedef struct packed {
        logic                   we;
        logic [M20K_ADDR_W-1:0] addr;
        logic [M20K_DATA_W-1:0] wdata;
        logic [M20K_DATA_W-1:0] wem;
    } m20k_req_t;

    typedef struct packed {
        logic [STAT_W-1:0] rd;
        logic [STAT_W-1:0] wr;
        logic [STAT_W-1:0] stall;
    } m20k_stats_t;

    // Saturating increment; counters stick at all-ones.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
        return (en && (v != {STAT_W{1'b1}})) ? v + STAT_W'(1) : v;
    endfunction

endpackage

// File: rtl/m20k_rsp_fifo.sv
// Circular response buffer: registered storage, combinational head, occupancy count.
module m20k_rsp_fifo #(
    parameter  int DATA_W    = 2,
    parameter  int RSP_DEPTH = 3,
    localparam int PTR_W     = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1,
    localparam int CNT_W     = $clog2(RSP_DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic [CNT_W-1:0]  count_o
);

    logic [DATA_W-1:0] store_q [RSP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              pop_ok;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Pop is ignored when empty so a stray request cannot corrupt the pointers.
    assign pop_ok = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wrap_inc(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = wrap_inc(rd_ptr_q);
        end
        case ({push_i, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_i) begin
            store_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = store_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/m20k_port_ctrl.sv
// Valid/ready front-end for one M20K port; turns 1-cycle read latency into a credited response stream.
// Optional statistics counters are enabled by M20K_PORT_STATS_EN.
module m20k_port_ctrl
    import m20k_pkg::*;
#(
    parameter int ADDR_W    = M20K_ADDR_W,
    parameter int DATA_W    = M20K_DATA_W,
    parameter int RSP_DEPTH = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [DATA_W-1:0] req_wem,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_d,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wem,
    input  logic [DATA_W-1:0] mem_q
`ifdef M20K_PORT_STATS_EN
    ,
    output logic [15:0]       stat_rd,
    output logic [15:0]       stat_wr,
    output logic [15:0]       stat_stall
`endif
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    m20k_req_t        req_s;
    logic             inflight_q, inflight_d;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   occ;
    logic             credit;
    logic             accept;
    logic             rd_acc;
    logic             pop;
    logic [DATA_W-1:0] head;

    assign req_s.we    = req_we;
    assign req_s.addr  = req_addr;
    assign req_s.wdata = req_wdata;
    assign req_s.wem   = req_wem;

    // Credits count both buffered data and the read whose Q arrives this cycle,
    // so the FIFO can never overflow and rsp_ready never reaches req_ready.
    assign occ       = (CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(inflight_q);
    assign credit    = occ < (CNT_W + 1)'(RSP_DEPTH);
    assign req_ready = ~RST & (req_s.we | credit);
    assign accept    = req_valid & req_ready;
    assign rd_acc    = accept & ~req_s.we;

    assign mem_ce  = accept;
    assign mem_we  = req_s.we & ~RST;
    assign mem_a   = req_s.addr;
    assign mem_d   = req_s.wdata;
    assign mem_wem = req_s.wem;

    always_comb begin
        inflight_d = rd_acc;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    assign rsp_valid = (fifo_count != '0);
    assign pop       = rsp_valid & rsp_ready;
    // Empty buffer presents zero rather than a stale entry.
    assign rsp_data  = rsp_valid ? head : '0;

    m20k_rsp_fifo #(
        .DATA_W    (DATA_W),
        .RSP_DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .CLK         (CLK),
        .RST         (RST),
        .push_i      (inflight_q),
        .push_data_i (mem_q),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (fifo_count)
    );

`ifdef M20K_PORT_STATS_EN
    m20k_stats_t stats_q, stats_d;
    logic        wr_acc;
    logic        stall;

    assign wr_acc = accept & req_s.we;
    assign stall  = req_valid & ~req_ready;

    always_comb begin
        stats_d       = stats_q;
        stats_d.rd    = sat_inc(stats_q.rd, rd_acc);
        stats_d.wr    = sat_inc(stats_q.wr, wr_acc);
        stats_d.stall = sat_inc(stats_q.stall, stall);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stats_q <= '0;
        end else begin
            stats_q <= stats_d;
        end
    end

    assign stat_rd    = stats_q.rd;
    assign stat_wr    = stats_q.wr;
    assign stat_stall = stats_q.stall;
`else
    // Statistics disabled: no counters and no stat ports.
`endif

endmodule

// File: tb/tb_m20k_port_ctrl.sv
// Directed bench for m20k_port_ctrl with a behavioural M20K port model (NEW_DATA, 1-cycle Q).
// Statistics checks are compiled in when M20K_PORT_STATS_EN is defined.
module tb_m20k_port_ctrl;

    logic        CLK;
    logic        RST;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [12:0] req_addr;
    logic [1:0]  req_wdata;
    logic [1:0]  req_wem;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_data;
    logic [12:0] mem_a;
    logic [1:0]  mem_d;
    logic        mem_ce;
    logic        mem_we;
    logic [1:0]  mem_wem;
    logic [1:0]  q_m;
`ifdef M20K_PORT_STATS_EN
    logic [15:0] stat_rd;
    logic [15:0] stat_wr;
    logic [15:0] stat_stall;
`endif

    int tests = 0;
    int fails = 0;

    logic [1:0] mem_m [8192];
    logic [1:0] pat [8];

    m20k_port_ctrl dut (
        .CLK        (CLK),
        .RST        (RST),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wem    (req_wem),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .mem_a      (mem_a),
        .mem_d      (mem_d),
        .mem_ce     (mem_ce),
        .mem_we     (mem_we),
        .mem_wem    (mem_wem),
        .mem_q      (q_m)
`ifdef M20K_PORT_STATS_EN
        ,
        .stat_rd    (stat_rd),
        .stat_wr    (stat_wr),
        .stat_stall (stat_stall)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Macro port model: masked write, Q shows the addressed word one cycle after CE.
    always @(posedge CLK) begin
        if (mem_ce) begin
            if (mem_we) begin
                mem_m[mem_a] <= (mem_m[mem_a] & ~mem_wem) | (mem_d & mem_wem);
                q_m          <= (mem_m[mem_a] & ~mem_wem) | (mem_d & mem_wem);
            end else begin
                q_m <= mem_m[mem_a];
            end
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic v, input logic we, input logic [12:0] a,
                       input logic [1:0] d, input logic [1:0] m, input logic rr);
        @(negedge CLK);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_wem   = m;
        rsp_ready = rr;
        #1;
    endtask

    initial begin
        pat[0] = 2'd2; pat[1] = 2'd0; pat[2] = 2'd3; pat[3] = 2'd1;
        pat[4] = 2'd1; pat[5] = 2'd3; pat[6] = 2'd0; pat[7] = 2'd2;
        q_m = 2'b00;
        RST = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_wem = '0; rsp_ready = 1'b0;

        // Reset state, with a write request pending
        repeat (2) @(negedge CLK);
        req_valid = 1'b1; req_we = 1'b1;
        #1;
        chk("rst_req_ready", 16'(req_ready), 16'h0);
        chk("rst_mem_ce", 16'(mem_ce), 16'h0);
        chk("rst_mem_we", 16'(mem_we), 16'h0);
        chk("rst_rsp_valid", 16'(rsp_valid), 16'h0);
        chk("rst_rsp_data", 16'(rsp_data), 16'h0);
`ifdef M20K_PORT_STATS_EN
        chk("rst_stat_rd", stat_rd, 16'h0);
        chk("rst_stat_stall", stat_stall, 16'h0);
`endif
        @(negedge CLK);
        RST = 1'b0; req_valid = 1'b0; req_we = 1'b0;

        // Write 0x0005 <- 2'b10, read back with 2-cycle latency
        drv(1, 1, 13'h0005, 2'b10, 2'b11, 1);
        chk("t1_wr_ready", 16'(req_ready), 16'h1);
        chk("t1_wr_ce", 16'(mem_ce), 16'h1);
        chk("t1_wr_we", 16'(mem_we), 16'h1);
        chk("t1_wr_a", 16'(mem_a), 16'h0005);
        chk("t1_wr_d", 16'(mem_d), 16'h2);
        chk("t1_wr_wem", 16'(mem_wem), 16'h3);
        drv(1, 0, 13'h0005, 2'b00, 2'b00, 1);
        chk("t1_rd_ready", 16'(req_ready), 16'h1);
        chk("t1_rd_we", 16'(mem_we), 16'h0);
        drv(0, 0, 13'h0, 2'b00, 2'b00, 1);
        chk("t1_lat1_valid", 16'(rsp_valid), 16'h0);
        drv(0, 0, 13'h0, 2'b00, 2'b00, 1);
        chk("t1_lat2_valid", 16'(rsp_valid), 16'h1);
        chk("t1_lat2_data", 16'(rsp_data), 16'h2);
        drv(0, 0, 13'h0, 2'b00, 2'b00, 1);
        chk("t1_after_valid", 16'(rsp_valid), 16'h0);

        // Masked write at the top address
        drv(1, 1, 13'h1FFF, 2'b11, 2'b11, 1);
        drv(1, 1, 13'h1FFF, 2'b00, 2'b01, 1);
        drv(1, 0, 13'h1FFF, 2'b00, 2'b00, 1);
        drv(0, 0, 13'h0, 2'b00, 2'b00, 1);
        chk("t2_lat1_valid", 16'(rsp_valid), 16'h0);
        drv(0, 0, 13'h0, 2'b00, 2'b00, 1);
        chk("t2_valid", 16'(rsp_valid), 16'h1);
        chk("t2_data", 16'(rsp_data), 16'h2);
        drv(0, 0, 13'h0, 2'b00, 2'b00, 1);
        chk("t2_after_valid", 16'(rsp_valid), 16'h0);

        // Eight back-to-back reads at full rate
        for (int k = 0; k < 8; k++) drv(1, 1, 13'(16 + k), pat[k], 2'b11, 1);
        for (int k = 0; k < 10; k++) begin
            if (k < 8) drv(1, 0, 13'(16 + k), 2'b00, 2'b00, 1);
            else       drv(0, 0, 13'h0, 2'b00, 2'b00, 1);
            if (k < 8) chk($sformatf("t3_ready_%0d", k), 16'(req_ready), 16'h1);
            if (k >= 2) begin
                chk($sformatf("t3_valid_%0d", k), 16'(rsp_valid), 16'h1);
                chk($sformatf("t3_data_%0d", k), 16'(rsp_data), 16'(pat[k-2]));
            end else begin
                chk($sformatf("t3_valid_%0d", k), 16'(rsp_valid), 16'h0);
            end
        end
        drv(0, 0, 13'h0, 2'b00, 2'b00, 1);
        chk("t3_drained", 16'(rsp_valid), 16'h0);

        // Backpressure: 3 reads accepted, then reads blocked but writes pass
        for (int k = 0; k < 5; k++) begin
            drv(1, 0, 13'(16 + k), 2'b00, 2'b00, 0);
            chk($sformatf("t4_ready_%0d", k), 16'(req_ready), (k < 3) ? 16'h1 : 16'h0);
            if (k >= 2) chk($sformatf("t4_hold_%0d", k), 16'(rsp_data), 16'(pat[0]));
        end
        drv(1, 1, 13'h0020, 2'b01, 2'b11, 0);
        chk("t4_wr_ready", 16'(req_ready), 16'h1);
        chk("t4_wr_ce", 16'(mem_ce), 16'h1);
        chk("t4_wr_hold", 16'(rsp_data), 16'(pat[0]));
        drv(1, 0, 13'h0013, 2'b00, 2'b00, 0);
        chk("t4_rd_blocked", 16'(req_ready), 16'h0);
        chk("t4_rd_no_ce", 16'(mem_ce), 16'h0);
        for (int k = 0; k < 3; k++) begin
            drv(0, 0, 13'h0, 2'b00, 2'b00, 1);
            chk($sformatf("t4_drain_valid_%0d", k), 16'(rsp_valid), 16'h1);
            chk($sformatf("t4_drain_data_%0d", k), 16'(rsp_data), 16'(pat[k]));
        end
        drv(0, 0, 13'h0, 2'b00, 2'b00, 1);
        chk("t4_empty", 16'(rsp_valid), 16'h0);

        // Reset with two buffered responses and one inflight read
        for (int k = 0; k < 3; k++) drv(1, 0, 13'(20 + k), 2'b00, 2'b00, 0);
        drv(1, 0, 13'h0030, 2'b00, 2'b00, 0);
        chk("t5_pre_valid", 16'(rsp_valid), 16'h1);
        chk("t5_pre_data", 16'(rsp_data), 16'(pat[4]));
        req_we = 1'b1;
        RST = 1'b1;
        #1;
        chk("t5_rst_valid", 16'(rsp_valid), 16'h0);
        chk("t5_rst_data", 16'(rsp_data), 16'h0);
        chk("t5_rst_ready", 16'(req_ready), 16'h0);
        chk("t5_rst_ce", 16'(mem_ce), 16'h0);
        chk("t5_rst_we", 16'(mem_we), 16'h0);
        @(negedge CLK);
        RST = 1'b0;
        drv(0, 0, 13'h0, 2'b00, 2'b00, 1);
        chk("t5_rel_ready", 16'(req_ready), 16'h1);
        for (int k = 0; k < 3; k++) begin
            drv(0, 0, 13'h0, 2'b00, 2'b00, 1);
            chk($sformatf("t5_no_spurious_%0d", k), 16'(rsp_valid), 16'h0);
        end
        drv(1, 0, 13'h0017, 2'b00, 2'b00, 1);
        drv(0, 0, 13'h0, 2'b00, 2'b00, 1);
        drv(0, 0, 13'h0, 2'b00, 2'b00, 1);
        chk("t5_post_valid", 16'(rsp_valid), 16'h1);
        chk("t5_post_data", 16'(rsp_data), 16'(pat[7]));
        drv(0, 0, 13'h0, 2'b00, 2'b00, 1);

`ifdef M20K_PORT_STATS_EN
        // Statistics: 5 reads, 3 writes, 4 stall cycles, then saturation
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("t6_clr_rd", stat_rd, 16'h0);
        for (int k = 0; k < 3; k++) drv(1, 1, 13'(64 + k), 2'(k), 2'b11, 1);
        for (int k = 0; k < 7; k++) drv(1, 0, 13'(16 + k), 2'b00, 2'b00, 0);
        for (int k = 0; k < 3; k++) drv(0, 0, 13'h0, 2'b00, 2'b00, 1);
        for (int k = 0; k < 2; k++) drv(1, 0, 13'(16 + k), 2'b00, 2'b00, 1);
        for (int k = 0; k < 3; k++) drv(0, 0, 13'h0, 2'b00, 2'b00, 1);
        chk("t6_stat_rd", stat_rd, 16'd5);
        chk("t6_stat_wr", stat_wr, 16'd3);
        chk("t6_stat_stall", stat_stall, 16'd4);
        for (int k = 0; k < 70010; k++) drv(1, 0, 13'h0010, 2'b00, 2'b00, 0);
        chk("t6_stall_sat", stat_stall, 16'hFFFF);
        chk("t6_rd_after_sat", stat_rd, 16'd8);
        drv(0, 0, 13'h0, 2'b00, 2'b00, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
